// File: rtl/muldiv_unit_pkg.sv
// Shared op/port codes for the multiply/divide unit and the decoder that drives it.
package muldiv_unit_pkg;
  localparam logic [2:0] MDC_MULT  = 3'b000;
  localparam logic [2:0] MDC_MULTU = 3'b001;
  localparam logic [2:0] MDC_DIV   = 3'b010;
  localparam logic [2:0] MDC_DIVU  = 3'b011;
  localparam logic [2:0] MDC_MADD  = 3'b100;

  localparam logic [1:0] MDM_HI = 2'b01;
  localparam logic [1:0] MDM_LO = 2'b10;

  function automatic logic mdc_legal(input logic [2:0] op);
    return (op <= MDC_MADD);
  endfunction

  function automatic logic mdc_is_div(input logic [2:0] op);
    return (op == MDC_DIV) || (op == MDC_DIVU);
  endfunction
endpackage

// File: rtl/muldiv_unit_md_arith.sv
// Combinational datapath: 64-bit {HI,LO} result for the latched op, plus a divide-by-zero flag.
module md_arith
  import muldiv_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] res,
  output logic        div0
);
  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic        [31:0] w_bdiv;
  logic signed [31:0] w_sq, w_sr;
  logic        [31:0] w_uq, w_ur;
  logic               w_ovf;

  assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_uprod = {32'b0, a} * {32'b0, b};

  // 0x80000000 / -1 is divided by +1 instead: yields q=0x80000000, r=0 without overflow.
  assign w_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign w_bdiv = (b == 32'd0 || w_ovf) ? 32'd1 : b;
  assign w_sq   = $signed(a) / $signed(w_bdiv);
  assign w_sr   = $signed(a) % $signed(w_bdiv);
  assign w_uq   = a / w_bdiv;
  assign w_ur   = a % w_bdiv;

  always_comb begin
    res  = hilo;
    div0 = 1'b0;
    case (op)
      MDC_MULT:  res = w_sprod;
      MDC_MULTU: res = w_uprod;
      MDC_MADD:  res = hilo + w_sprod;
      MDC_DIV: begin
        res  = {w_sr, w_sq};
        div0 = (b == 32'd0);
      end
      MDC_DIVU: begin
        res  = {w_ur, w_uq};
        div0 = (b == 32'd0);
      end
      default: res = hilo;
    endcase
  end
endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: HI/LO registers, fixed-latency busy counter, mthi/mtlo and mfhi/mflo.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDCCtrl,
  input  logic [1:0]  MDM_WE,
  input  logic [1:0]  MDM_RE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] MDOut
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [31:0]   r_a, r_b, r_hi, r_lo;
  logic [63:0]   w_res;
  logic          w_div0;
  logic [CW-1:0] w_lat;

  md_arith u_arith (
    .op   (r_op),
    .a    (r_a),
    .b    (r_b),
    .hilo ({r_hi, r_lo}),
    .res  (w_res),
    .div0 (w_div0)
  );

  assign w_lat = mdc_is_div(MDCCtrl) ? CW'(DIV_LAT) : CW'(MUL_LAT);

  // Priority: reset > in-flight count/commit > start > mthi/mtlo.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (r_cnt != '0) begin
      if (r_cnt == CW'(1)) begin
        r_cnt <= '0;
        if (!w_div0) {r_hi, r_lo} <= w_res;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (start) begin
      if (mdc_legal(MDCCtrl)) begin
        r_op  <= MDCCtrl;
        r_a   <= A;
        r_b   <= B;
        r_cnt <= w_lat;
      end
    end else if (MDM_WE == MDM_HI) begin
      r_hi <= A;
    end else if (MDM_WE == MDM_LO) begin
      r_lo <= A;
    end
  end

  assign busy = (r_cnt != '0);

  always_comb begin
    MDOut = 32'd0;
    case (MDM_RE)
      MDM_HI:  MDOut = r_hi;
      MDM_LO:  MDOut = r_lo;
      default: MDOut = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against a cycle-level arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MDCCtrl = 3'd0;
  logic [1:0]  MDM_WE = 2'd0;
  logic [1:0]  MDM_RE = 2'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] MDOut;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDCCtrl(MDCCtrl),
    .MDM_WE(MDM_WE), .MDM_RE(MDM_RE), .A(A), .B(B),
    .busy(busy), .MDOut(MDOut)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference state: architectural HI/LO plus the pending op and cycles left
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic [2:0]  m_op = 0;
  int          m_left = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_commit();
    longint      sp;
    longint unsigned acc;
    int          q, r;
    sp = longint'(int'(m_a)) * longint'(int'(m_b));
    case (m_op)
      3'd0: {m_hi, m_lo} = sp;
      3'd1: {m_hi, m_lo} = {32'd0, m_a} * {32'd0, m_b};
      3'd4: begin
        acc = {m_hi, m_lo};
        acc = acc + longint'(sp);
        {m_hi, m_lo} = acc;
      end
      3'd2: if (m_b != 0) begin
        if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 0;
        end else begin
          q = int'(m_a) / int'(m_b);
          r = int'(m_a) % int'(m_b);
          m_lo = q; m_hi = r;
        end
      end
      3'd3: if (m_b != 0) begin
        m_lo = m_a / m_b; m_hi = m_a % m_b;
      end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_op = 0; m_left = 0;
    end else if (m_left > 0) begin
      if (m_left == 1) model_commit();
      m_left--;
    end else if (start) begin
      if (MDCCtrl <= 3'd4) begin
        m_op = MDCCtrl; m_a = A; m_b = B;
        m_left = (MDCCtrl == 3'd2 || MDCCtrl == 3'd3) ? 10 : 5;
      end
    end else if (MDM_WE == 2'b01) m_hi = A;
    else if (MDM_WE == 2'b10) m_lo = A;
  endtask

  logic [31:0] last_hi, last_lo;

  // one clock: drive, edge, then compare busy/HI/LO on the falling side
  task automatic cyc(input logic rst_n, input logic st, input logic [2:0] op,
                     input logic [1:0] we, input logic [31:0] a, input logic [31:0] b);
    reset = rst_n; start = st; MDCCtrl = op; MDM_WE = we; A = a; B = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; MDM_WE = 2'd0;
    chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
    MDM_RE = 2'b01; #1;
    chk("hi", MDOut, m_hi); last_hi = MDOut;
    MDM_RE = 2'b10; #1;
    chk("lo", MDOut, m_lo); last_lo = MDOut;
    MDM_RE = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    // 1: reset and idle readback
    cyc(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    idle(1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst hi", last_hi, 32'd0);
    chk("rst lo", last_lo, 32'd0);
    MDM_RE = 2'b11; #1;
    chk("re11 zero", MDOut, 32'd0);
    MDM_RE = 2'b00;

    // 2: mult / multu, 5 busy cycles each (checked per cycle by the model)
    cyc(1'b1, 1'b1, 3'd0, 2'd0, 32'hFFFF_FFFF, 32'd2);
    idle(5);
    chk("mult hi", last_hi, 32'hFFFF_FFFF);
    chk("mult lo", last_lo, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b1, 3'd1, 2'd0, 32'hFFFF_FFFF, 32'd2);
    idle(5);
    chk("multu hi", last_hi, 32'd1);
    chk("multu lo", last_lo, 32'hFFFF_FFFE);

    // 3: signed div, then divide by zero leaves HI/LO intact
    cyc(1'b1, 1'b1, 3'd2, 2'd0, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    chk("div lo", last_lo, 32'hFFFF_FFFD);
    chk("div hi", last_hi, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, 3'd3, 2'd0, 32'd7, 32'd0);
    idle(10);
    chk("div0 lo", last_lo, 32'hFFFF_FFFD);
    chk("div0 hi", last_hi, 32'hFFFF_FFFF);

    // 4: mthi/mtlo then madd with carry into HI; a start at busy cycle 3 is ignored
    cyc(1'b1, 1'b0, 3'd0, 2'b01, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 3'd0, 2'b10, 32'hFFFF_FFFF, 32'd0);
    cyc(1'b1, 1'b1, 3'd4, 2'd0, 32'd1, 32'd1);
    idle(1);
    cyc(1'b1, 1'b1, 3'd0, 2'd0, 32'd9, 32'd9);
    idle(3);
    chk("madd hi", last_hi, 32'd1);
    chk("madd lo", last_lo, 32'd0);
    idle(6);
    chk("madd once lo", last_lo, 32'd0);

    // signed overflow case
    cyc(1'b1, 1'b1, 3'd2, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("ovf lo", last_lo, 32'h8000_0000);
    chk("ovf hi", last_hi, 32'd0);

    // 5: reset at busy cycle 4 of a div aborts it
    cyc(1'b1, 1'b1, 3'd2, 2'd0, 32'd100, 32'd7);
    idle(2);
    cyc(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort lo", last_lo, 32'd0);
    idle(12);
    chk("no late hi", last_hi, 32'd0);
    chk("no late lo", last_lo, 32'd0);

    // 6: mtlo in the same cycle as start is dropped
    cyc(1'b1, 1'b1, 3'd0, 2'b10, 32'd3, 32'd4);
    chk("mtlo dropped", last_lo, 32'd0);
    idle(5);
    chk("st+we hi", last_hi, 32'd0);
    chk("st+we lo", last_lo, 32'd12);

    // random mix: ops (incl. reserved), overlapping starts, writes, rare resets
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), pick(), pick());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
